// File: rtl/vend_controller.sv
// Purpose  : vending transaction FSM that latches a selection, collects coins,
//            dispenses, and returns change or a refund.
// Latency  : coin accepted on cycle N shows in credit on N+1 and dispense pulses
//            on N+2. sel_error and coin_reject are registered and pulse on the
//            cycle after the event that causes them.
// Backpress: change is held on change_valid until change_ack. Coins that cannot
//            be taken are flagged on coin_reject and are never queued.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   sel_valid, select_in         customer selection (used in IDLE only)
//   sel_latched, price           registered selection out, price back from price_select
//   coin_valid, coin_value       coin input (00 = invalid code)
//   cancel                       customer abort
//   coin_reject, sel_error       1-cycle status pulses
//   dispense                     1-cycle release pulse for sel_latched
//   credit                       accumulated credit
//   change_valid, change, change_ack   change/refund handshake to the coin hopper
module vend_controller #(
   parameter int CREDIT_W = 5,
   parameter int TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sel_valid,
   input  logic [1:0]          select_in,
   output logic [1:0]          sel_latched,
   input  logic [3:0]          price,
   input  logic                coin_valid,
   input  logic [1:0]          coin_value,
   input  logic                cancel,
   output logic                coin_reject,
   output logic                sel_error,
   output logic                dispense,
   output logic [CREDIT_W-1:0] credit,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change,
   input  logic                change_ack
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_COLLECT,
      S_DISPENSE,
      S_REFUND
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          sel_q, sel_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sel_error_q, sel_error_d;

   logic [CREDIT_W-1:0] price_ext;
   logic [CREDIT_W-1:0] coin_amt;
   logic                coin_ok;

   assign price_ext = {{(CREDIT_W-4){1'b0}}, price};

   always_comb begin
      coin_amt = '0;
      case (coin_value)
         2'b01:   coin_amt = CREDIT_W'(1);
         2'b10:   coin_amt = CREDIT_W'(2);
         2'b11:   coin_amt = CREDIT_W'(5);
         default: coin_amt = '0;
      endcase
   end

   assign coin_ok = coin_valid && (coin_value != 2'b00);

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      credit_d      = credit_q;
      tmr_d         = tmr_q;
      sel_error_d   = 1'b0;
      // Every presented coin is rejected unless the COLLECT accept branch takes it.
      coin_reject_d = coin_valid;

      case (state_q)
         S_IDLE: begin
            if (sel_valid) begin
               sel_d   = select_in;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            // sel_latched has been stable for a cycle, so price is valid here.
            if (price == 4'd0) begin
               sel_error_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               tmr_d   = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (credit_q >= price_ext) begin
               state_d = S_DISPENSE;
            end else if (cancel || (tmr_q == TMR_LAST)) begin
               state_d = (credit_q != '0) ? S_REFUND : S_IDLE;
            end else if (coin_ok) begin
               credit_d      = credit_q + coin_amt;
               tmr_d         = '0;
               coin_reject_d = 1'b0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_DISPENSE: begin
            credit_d = credit_q - price_ext;
            state_d  = (credit_d != '0) ? S_REFUND : S_IDLE;
         end
         S_REFUND: begin
            if (change_ack) begin
               credit_d = '0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sel_q         <= 2'b00;
         credit_q      <= '0;
         tmr_q         <= '0;
         coin_reject_q <= 1'b0;
         sel_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         credit_q      <= credit_d;
         tmr_q         <= tmr_d;
         coin_reject_q <= coin_reject_d;
         sel_error_q   <= sel_error_d;
      end
   end

   assign sel_latched  = sel_q;
   assign credit       = credit_q;
   assign coin_reject  = coin_reject_q;
   assign sel_error    = sel_error_q;
   assign dispense     = (state_q == S_DISPENSE);
   assign change_valid = (state_q == S_REFUND);
   assign change       = change_valid ? credit_q : '0;

endmodule

// File: tb/tb_vend_controller.sv
// Purpose  : randomized and directed bench for vend_controller with a queue scoreboard.
// Latency  : expectations queued at stimulus time, checked when outputs appear.
// Backpress: bench plays the coin hopper and acks change after a random delay.
module tb_vend_controller;
   localparam int CW        = 5;
   localparam int M_PAY     = 0;
   localparam int M_CANCEL  = 1;
   localparam int M_TIMEOUT = 2;
   localparam int M_BAD     = 3;
   localparam int M_RESET   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sel_valid = 1'b0;
   logic [1:0]    select_in = 2'b00;
   logic [1:0]    sel_latched;
   logic [3:0]    price;
   logic          coin_valid = 1'b0;
   logic [1:0]    coin_value = 2'b00;
   logic          cancel = 1'b0;
   logic          coin_reject;
   logic          sel_error;
   logic          dispense;
   logic [CW-1:0] credit;
   logic          change_valid;
   logic [CW-1:0] change;
   logic          change_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   int q_disp[$];
   int q_selerr[$];
   int q_rej[$];
   int q_chg[$];
   int q_cred[$];
   int plan[$];

   bit mon_en = 1'b0;
   int prev_credit;
   bit prev_cv;
   int prev_chg;

   always #5 clk = ~clk;

   // Stand-in for price_select.
   always_comb begin
      case (sel_latched)
         2'b00:   price = 4'd5;
         2'b01:   price = 4'd7;
         2'b10:   price = 4'd10;
         default: price = 4'd0;
      endcase
   end

   vend_controller #(.CREDIT_W(CW), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .sel_valid    (sel_valid),
      .select_in    (select_in),
      .sel_latched  (sel_latched),
      .price        (price),
      .coin_valid   (coin_valid),
      .coin_value   (coin_value),
      .cancel       (cancel),
      .coin_reject  (coin_reject),
      .sel_error    (sel_error),
      .dispense     (dispense),
      .credit       (credit),
      .change_valid (change_valid),
      .change       (change),
      .change_ack   (change_ack)
   );

   function automatic int price_of(int s);
      int tbl[4] = '{5, 7, 10, 0};
      return tbl[s & 3];
   endfunction

   function automatic int value_of(int code);
      int tbl[4] = '{0, 1, 2, 5};
      return tbl[code & 3];
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel_latched"}, int'(sel_latched), 0);
      check({tag, "_credit"}, int'(credit), 0);
      check({tag, "_change"}, int'(change), 0);
      check({tag, "_change_valid"}, int'(change_valid), 0);
      check({tag, "_dispense"}, int'(dispense), 0);
      check({tag, "_sel_error"}, int'(sel_error), 0);
      check({tag, "_coin_reject"}, int'(coin_reject), 0);
   endtask

   // Monitor: pops the matching queue whenever the DUT presents an event.
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_credit = 0;
         prev_cv     = 1'b0;
         prev_chg    = 0;
      end else begin
         if (dispense) begin
            check("dispense_expected", int'(q_disp.size() > 0), 1);
            if (q_disp.size() > 0) check("dispense_sel", int'(sel_latched), q_disp.pop_front());
         end
         if (sel_error) begin
            check("sel_error_expected", int'(q_selerr.size() > 0), 1);
            if (q_selerr.size() > 0) check("sel_error_sel", int'(sel_latched), q_selerr.pop_front());
         end
         if (coin_reject) begin
            check("coin_reject_expected", int'(q_rej.size() > 0), 1);
            if (q_rej.size() > 0) void'(q_rej.pop_front());
         end
         if (change_valid && change_ack) begin
            check("change_expected", int'(q_chg.size() > 0), 1);
            if (q_chg.size() > 0) check("change_amount", int'(change), q_chg.pop_front());
         end
         if (change_valid && prev_cv) check("change_stable", int'(change), prev_chg);
         if (int'(credit) != prev_credit) begin
            check("credit_change_expected", int'(q_cred.size() > 0), 1);
            if (q_cred.size() > 0) check("credit_value", int'(credit), q_cred.pop_front());
         end
         prev_credit = int'(credit);
         prev_cv     = change_valid;
         prev_chg    = int'(change);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input bit cv, input int code, input bit can);
      coin_valid = cv;
      coin_value = 2'(code);
      cancel     = can;
      cyc();
      coin_valid = 1'b0;
      coin_value = 2'b00;
      cancel     = 1'b0;
   endtask

   // Waits for change_valid, returns how many cycles it took, then acks or resets.
   task automatic refund(input int c, input int ack_delay, input bit do_reset, output int n);
      bit seen;
      int d;
      n = 0;
      forever begin
         @(negedge clk);
         seen = change_valid;
         cyc();
         if (seen) break;
         n++;
         if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL change_valid_wait: never asserted, expected change %0d", c);
            return;
         end
      end
      if (do_reset) begin
         q_cred.push_back(0);
         rst = 1'b1;
         cyc();
         rst = 1'b0;
         @(negedge clk);
         check_all_zero("mid_reset");
         cyc();
         return;
      end
      if ($urandom_range(0, 1) == 1) begin
         // Coin, cancel and a new selection during refund: only the coin reacts.
         q_rej.push_back(1);
         coin_valid = 1'b1;
         coin_value = 2'($urandom_range(1, 3));
         cancel     = 1'b1;
         sel_valid  = 1'b1;
         select_in  = 2'($urandom_range(0, 3));
         cyc();
         coin_valid = 1'b0;
         coin_value = 2'b00;
         cancel     = 1'b0;
         sel_valid  = 1'b0;
      end
      d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
      repeat (d) cyc();
      q_chg.push_back(c);
      q_cred.push_back(0);
      change_ack = 1'b1;
      cyc();
      change_ack = 1'b0;
   endtask

   task automatic do_txn(input int sel, input int mode, input bit fixed,
                         input int cancel_coin, input int ack_delay);
      int  price_v, c, code, v, k, n;
      bit  last_bad;
      price_v  = price_of(sel);
      c        = 0;
      n        = 0;
      last_bad = 1'b0;
      sel_valid = 1'b1;
      select_in = 2'(sel);
      cyc();
      sel_valid = 1'b0;
      cyc();
      if (mode == M_BAD) begin
         q_selerr.push_back(sel);
         q_rej.push_back(1);
         put(1'b1, int'($urandom_range(1, 3)), 1'b0);
         return;
      end
      if (mode == M_PAY || mode == M_RESET) begin
         while (c < price_v) begin
            if (fixed) begin
               code = (plan.size() > 0) ? plan.pop_front() : 2;
            end else begin
               repeat ($urandom_range(0, 3)) cyc();
               code = last_bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            end
            last_bad = (code == 0);
            if (code == 0) begin
               q_rej.push_back(1);
               put(1'b1, 0, 1'b0);
            end else begin
               c += value_of(code);
               q_cred.push_back(c);
               put(1'b1, code, 1'b0);
            end
         end
         q_disp.push_back(sel);
         c -= price_v;
         q_cred.push_back(c);
         if (c > 0) begin
            refund(c, ack_delay, mode == M_RESET, n);
            check("pay_to_refund_cycles", n, 2);
         end else begin
            cyc();
            cyc();
         end
      end else begin
         k = fixed ? plan.size() : int'($urandom_range(0, 2));
         for (int i = 0; i < k; i++) begin
            code = fixed ? plan.pop_front() : int'($urandom_range(1, 3));
            v = value_of(code);
            if (c + v >= price_v) continue;
            if (!fixed) repeat ($urandom_range(0, 2)) cyc();
            c += v;
            q_cred.push_back(c);
            put(1'b1, code, 1'b0);
         end
         if (mode == M_CANCEL) begin
            code = (cancel_coin >= 0) ? cancel_coin : int'($urandom_range(0, 3));
            if (code != 0) q_rej.push_back(1);
            put(code != 0, code, 1'b1);
            if (c > 0) begin
               refund(c, ack_delay, 1'b0, n);
               check("cancel_to_refund_cycles", n, 0);
            end
         end else if (c > 0) begin
            refund(c, ack_delay, 1'b0, n);
            check("timeout_cycles", n, 16);
         end else begin
            repeat (18) cyc();
            @(negedge clk);
            check("timeout_empty_change_valid", int'(change_valid), 0);
            check("timeout_empty_credit", int'(credit), 0);
            cyc();
         end
      end
   endtask

   initial begin
      int mode;
      repeat (3) cyc();
      @(negedge clk);
      check_all_zero("reset");
      cyc();
      rst    = 1'b0;
      mon_en = 1'b1;

      plan = '{3, 2};    do_txn(1, M_PAY, 1'b1, 0, -1);      // 7: 5+2, no change
      plan = '{2, 2, 2}; do_txn(0, M_PAY, 1'b1, 0, 3);       // 5: change 1, ack after 3
      do_txn(3, M_BAD, 1'b1, 0, -1);                         // price 0
      plan = '{3};       do_txn(2, M_CANCEL, 1'b1, 2, -1);   // 5 then cancel with coin 2
      plan = '{2};       do_txn(1, M_TIMEOUT, 1'b1, 0, -1);  // refund 2 after timeout
      plan = '{};        do_txn(1, M_TIMEOUT, 1'b1, 0, -1);  // timeout with nothing
      plan = '{0, 2, 2, 2}; do_txn(0, M_RESET, 1'b1, 0, -1); // invalid coin, reset in refund

      for (int t = 0; t < 40; t++) begin
         mode = int'($urandom_range(0, 3));
         if (mode == M_BAD) do_txn(3, M_BAD, 1'b0, -1, -1);
         else do_txn(int'($urandom_range(0, 2)), mode, 1'b0, -1, -1);
      end

      repeat (5) cyc();
      check("left_dispense", q_disp.size(), 0);
      check("left_sel_error", q_selerr.size(), 0);
      check("left_coin_reject", q_rej.size(), 0);
      check("left_change", q_chg.size(), 0);
      check("left_credit", q_cred.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
